// File: rtl/door_sequencer.sv
// Latches side/panic call requests, arbitrates them round-robin into one-cycle grants
// for the door FSM, and produces the per-state seconds timebase.
module door_sequencer #(
    parameter int CLK_HZ   = 50000000,
    parameter int SEC_W    = 4,
    parameter int STATE_W  = 3,
    parameter int ST_IDLE  = 0,
    parameter int ST_PANIC = 4,
    parameter int GRANT_TO = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_0,
    input  logic               req_1,
    input  logic               panic_req,
    input  logic               panic_clr,
    input  logic [STATE_W-1:0] state_reg,
    output logic               grant_0,
    output logic               grant_1,
    output logic               grant_panic,
    output logic [SEC_W-1:0]   sec_t,
    output logic               sec_tick,
    output logic               pend_0,
    output logic               pend_1,
    output logic               last_served,
    output logic               locked
);

    localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int TO_W  = $clog2(GRANT_TO + 1);
    localparam logic [PRE_W-1:0]   PRE_TERM = PRE_W'(CLK_HZ - 1);
    localparam logic [TO_W-1:0]    TO_TERM  = TO_W'(GRANT_TO - 1);
    localparam logic [TO_W-1:0]    TO_MAX   = {TO_W{1'b1}};
    localparam logic [SEC_W-1:0]   SEC_MAX  = {SEC_W{1'b1}};
    localparam logic [STATE_W-1:0] S_IDLE   = STATE_W'(ST_IDLE);
    localparam logic [STATE_W-1:0] S_PANIC  = STATE_W'(ST_PANIC);

    typedef enum logic [1:0] {
        ARB_READY,
        ARB_BUSY,
        ARB_LOCK
    } arb_t;

    arb_t               arb_q, arb_d;
    logic [STATE_W-1:0] prev_q, prev_d;
    logic [PRE_W-1:0]   presc_q, presc_d;
    logic [SEC_W-1:0]   sec_q, sec_d;
    logic               tick_q, tick_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic               seen_q, seen_d;
    logic               pend_0_q, pend_0_d;
    logic               pend_1_q, pend_1_d;
    logic               last_q, last_d;
    logic               lock_q, lock_d;
    logic               g0_q, g0_d;
    logic               g1_q, g1_d;
    logic               gp_q, gp_d;
    logic               fsm_idle;
    logic               pick_0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arb_q    <= ARB_READY;
            prev_q   <= S_IDLE;
            presc_q  <= '0;
            sec_q    <= '0;
            tick_q   <= 1'b0;
            to_q     <= '0;
            seen_q   <= 1'b0;
            pend_0_q <= 1'b0;
            pend_1_q <= 1'b0;
            last_q   <= 1'b1;
            lock_q   <= 1'b0;
            g0_q     <= 1'b0;
            g1_q     <= 1'b0;
            gp_q     <= 1'b0;
        end else begin
            arb_q    <= arb_d;
            prev_q   <= prev_d;
            presc_q  <= presc_d;
            sec_q    <= sec_d;
            tick_q   <= tick_d;
            to_q     <= to_d;
            seen_q   <= seen_d;
            pend_0_q <= pend_0_d;
            pend_1_q <= pend_1_d;
            last_q   <= last_d;
            lock_q   <= lock_d;
            g0_q     <= g0_d;
            g1_q     <= g1_d;
            gp_q     <= gp_d;
        end
    end

    always_comb begin
        arb_d    = arb_q;
        prev_d   = state_reg;
        presc_d  = presc_q;
        sec_d    = sec_q;
        tick_d   = 1'b0;
        to_d     = to_q;
        seen_d   = seen_q;
        pend_0_d = pend_0_q;
        pend_1_d = pend_1_q;
        last_d   = last_q;
        g0_d     = 1'b0;
        g1_d     = 1'b0;
        gp_d     = 1'b0;
        fsm_idle = (state_reg == S_IDLE);
        // Tie goes to the side that was not served last.
        pick_0   = pend_0_q && (!pend_1_q || last_q);

        if ((state_reg != prev_q) || fsm_idle || (state_reg == S_PANIC)) begin
            presc_d = '0;
            sec_d   = '0;
        end else if (presc_q == PRE_TERM) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (sec_q != SEC_MAX) begin
                sec_d = sec_q + 1'b1;
            end
        end else begin
            presc_d = presc_q + 1'b1;
        end

        case (arb_q)
            ARB_READY: begin
                if (fsm_idle && (pend_0_q || pend_1_q)) begin
                    g0_d   = pick_0;
                    g1_d   = !pick_0;
                    last_d = !pick_0;
                    if (pick_0) begin
                        pend_0_d = 1'b0;
                    end else begin
                        pend_1_d = 1'b0;
                    end
                    arb_d  = ARB_BUSY;
                    to_d   = '0;
                    seen_d = 1'b0;
                end
            end
            ARB_BUSY: begin
                if (seen_q && fsm_idle) begin
                    arb_d  = ARB_READY;
                    seen_d = 1'b0;
                end else if (!seen_q && fsm_idle && (to_q == TO_TERM)) begin
                    // FSM never left IDLE: the grant was lost, so re-queue it.
                    if (last_q) begin
                        pend_1_d = 1'b1;
                    end else begin
                        pend_0_d = 1'b1;
                    end
                    arb_d = ARB_READY;
                end else begin
                    if (!fsm_idle) begin
                        seen_d = 1'b1;
                    end
                    if (to_q != TO_MAX) begin
                        to_d = to_q + 1'b1;
                    end
                end
            end
            ARB_LOCK: begin
                if (panic_clr && !panic_req) begin
                    arb_d = ARB_READY;
                end
            end
            default: arb_d = ARB_READY;
        endcase

        if (arb_q != ARB_LOCK) begin
            if (req_0) begin
                pend_0_d = 1'b1;
            end
            if (req_1) begin
                pend_1_d = 1'b1;
            end
        end

        // Panic overrides everything, including a grant decided this same edge.
        if (panic_req && (arb_q != ARB_LOCK)) begin
            g0_d     = 1'b0;
            g1_d     = 1'b0;
            gp_d     = 1'b1;
            pend_0_d = 1'b0;
            pend_1_d = 1'b0;
            last_d   = last_q;
            seen_d   = 1'b0;
            arb_d    = ARB_LOCK;
        end

        lock_d = (arb_d == ARB_LOCK);
    end

    assign grant_0     = g0_q;
    assign grant_1     = g1_q;
    assign grant_panic = gp_q;
    assign sec_t       = sec_q;
    assign sec_tick    = tick_q;
    assign pend_0      = pend_0_q;
    assign pend_1      = pend_1_q;
    assign last_served = last_q;
    assign locked      = lock_q;

endmodule

// File: tb/tb_door_sequencer.sv
// Bench for door_sequencer: reference model pushes expected outputs per edge,
// a monitor pops and compares on the falling edge.
module tb_door_sequencer;

    localparam int CLK_HZ   = 10;
    localparam int GRANT_TO = 16;
    localparam int SEC_MAX  = 15;

    typedef struct packed {
        logic       g0;
        logic       g1;
        logic       gp;
        logic [3:0] sec;
        logic       tick;
        logic       p0;
        logic       p1;
        logic       last;
        logic       lk;
    } obs_t;

    logic       clk;
    logic       rst;
    logic       req_0, req_1, panic_req, panic_clr;
    logic [2:0] state_reg;
    logic       grant_0, grant_1, grant_panic;
    logic [3:0] sec_t;
    logic       sec_tick, pend_0, pend_1, last_served, locked;

    int vectors     = 0;
    int miscompares = 0;

    obs_t exp_q[$];

    door_sequencer #(
        .CLK_HZ  (CLK_HZ),
        .SEC_W   (4),
        .STATE_W (3),
        .ST_IDLE (0),
        .ST_PANIC(4),
        .GRANT_TO(GRANT_TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_0      (req_0),
        .req_1      (req_1),
        .panic_req  (panic_req),
        .panic_clr  (panic_clr),
        .state_reg  (state_reg),
        .grant_0    (grant_0),
        .grant_1    (grant_1),
        .grant_panic(grant_panic),
        .sec_t      (sec_t),
        .sec_tick   (sec_tick),
        .pend_0     (pend_0),
        .pend_1     (pend_1),
        .last_served(last_served),
        .locked     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: cycles spent in the current timed state, plus request/lockout bookkeeping.
    int m_prev   = 0;
    int m_n      = 0;
    int m_cyc    = 0;
    int m_gcyc   = 0;
    bit m_p0     = 0;
    bit m_p1     = 1'b0;
    bit m_last   = 1'b1;
    bit m_locked = 1'b0;
    bit m_busy   = 1'b0;
    bit m_seen   = 1'b0;

    always @(posedge clk or posedge rst) begin
        obs_t e;
        int   st;
        bit   side;
        if (rst) begin
            m_prev = 0; m_n = 0; m_cyc = 0; m_gcyc = 0;
            m_p0 = 0; m_p1 = 0; m_last = 1; m_locked = 0; m_busy = 0; m_seen = 0;
            exp_q.delete();
        end else begin
            e  = '0;
            st = int'(state_reg);
            if (st != m_prev || st == 0 || st == 4) m_n = 0;
            else m_n = m_n + 1;
            m_prev = st;
            e.sec  = 4'((m_n / CLK_HZ > SEC_MAX) ? SEC_MAX : m_n / CLK_HZ);
            e.tick = (m_n != 0) && (m_n % CLK_HZ == 0);
            m_cyc  = m_cyc + 1;

            if (panic_req && !m_locked) begin
                e.gp = 1; m_p0 = 0; m_p1 = 0; m_locked = 1; m_busy = 0; m_seen = 0;
            end else if (m_locked) begin
                if (panic_clr && !panic_req) m_locked = 0;
            end else begin
                if (!m_busy) begin
                    if (st == 0 && (m_p0 || m_p1)) begin
                        side = (m_p0 && m_p1) ? !m_last : m_p1;
                        if (side) begin e.g1 = 1; m_p1 = 0; end
                        else begin e.g0 = 1; m_p0 = 0; end
                        m_last = side; m_busy = 1; m_seen = 0; m_gcyc = m_cyc;
                    end
                end else if (m_seen && st == 0) begin
                    m_busy = 0; m_seen = 0;
                end else if (!m_seen && st == 0 && (m_cyc - m_gcyc) == GRANT_TO) begin
                    if (m_last) m_p1 = 1; else m_p0 = 1;
                    m_busy = 0;
                end else if (st != 0) begin
                    m_seen = 1;
                end
                if (req_0) m_p0 = 1;
                if (req_1) m_p1 = 1;
            end
            e.p0 = m_p0; e.p1 = m_p1; e.last = m_last; e.lk = m_locked;
            exp_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        obs_t a, e;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{grant_0, grant_1, grant_panic, sec_t, sec_tick, pend_0, pend_1, last_served, locked};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL outputs @%0t: got g0=%b g1=%b gp=%b sec=%0d tick=%b p0=%b p1=%b last=%b lock=%b, expected g0=%b g1=%b gp=%b sec=%0d tick=%b p0=%b p1=%b last=%b lock=%b",
                         $time, a.g0, a.g1, a.gp, a.sec, a.tick, a.p0, a.p1, a.last, a.lk,
                         e.g0, e.g1, e.gp, e.sec, e.tick, e.p0, e.p1, e.last, e.lk);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " grant_0"}, int'(grant_0), 0);
        chk({tag, " grant_1"}, int'(grant_1), 0);
        chk({tag, " grant_panic"}, int'(grant_panic), 0);
        chk({tag, " sec_t"}, int'(sec_t), 0);
        chk({tag, " sec_tick"}, int'(sec_tick), 0);
        chk({tag, " pend_0"}, int'(pend_0), 0);
        chk({tag, " pend_1"}, int'(pend_1), 0);
        chk({tag, " last_served"}, int'(last_served), 1);
        chk({tag, " locked"}, int'(locked), 0);
    endtask

    task automatic cyc(input int st, input bit a, input bit b, input bit p, input bit c);
        state_reg = 3'(st);
        req_0     = a;
        req_1     = b;
        panic_req = p;
        panic_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        state_reg = '0; req_0 = 0; req_1 = 0; panic_req = 0; panic_clr = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int ticks;
        int cur;
        rst = 1'b1;
        state_reg = '0; req_0 = 0; req_1 = 0; panic_req = 0; panic_clr = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Timebase: ticks every CLK_HZ cycles in a held state, clear on change, saturate.
        ticks = 0;
        for (int i = 0; i < 35; i++) begin
            cyc(1, 0, 0, 0, 0);
            if (sec_tick) ticks++;
        end
        chk("tick count in 35 cycles", ticks, 3);
        chk("sec_t after 35 cycles", int'(sec_t), 3);
        cyc(2, 0, 0, 0, 0);
        chk("sec_t after state change", int'(sec_t), 0);
        for (int i = 0; i < 200; i++) cyc(1, 0, 0, 0, 0);
        chk("sec_t saturated", int'(sec_t), 15);

        // Single request on side 1.
        do_reset();
        cyc(0, 0, 1, 0, 0);
        chk("pend_1 after req", int'(pend_1), 1);
        cyc(0, 0, 0, 0, 0);
        chk("grant_1 one edge later", int'(grant_1), 1);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // Tie after reset, FSM walk, request while busy.
        do_reset();
        cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("tie goes to side 0", int'(grant_0), 1);
        for (int s = 1; s <= 3; s++) repeat (3) cyc(s, 0, s == 2, 0, 0);
        repeat (4) cyc(0, 0, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);

        // Panic while busy with side 0 pending, requests ignored under lockout.
        do_reset();
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        chk("grant_panic", int'(grant_panic), 1);
        cyc(4, 1, 0, 1, 1);
        repeat (3) cyc(4, 0, 0, 0, 0);
        cyc(4, 0, 0, 0, 1);
        chk("locked after clear", int'(locked), 0);
        repeat (3) cyc(0, 0, 0, 0, 0);

        // Lost grant: FSM stays idle.
        do_reset();
        cyc(0, 1, 0, 0, 0);
        repeat (40) cyc(0, 0, 0, 0, 0);

        // Async reset during BUSY with sec_t=5.
        do_reset();
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        repeat (55) cyc(1, 0, 0, 0, 0);
        chk("sec_t before async reset", int'(sec_t), 5);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized traffic: frequent then rare state changes.
        cur = 0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 3000; i++) begin
                int r;
                if ($urandom_range(0, (ph == 0) ? 7 : 39) == 0) begin
                    r   = int'($urandom_range(0, 9));
                    cur = (r < 4) ? 0 : (r % 4) + 1;
                end
                cyc(cur, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 63) == 0, $urandom_range(0, 11) == 0);
            end
        end
        repeat (2) cyc(0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
